// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a FWFT FIFO with per-frame error flags; define UART_RX_PARITY_EN for a parity bit; ports: clk, rst (async, active-high), rxd, baud_tick, read_en, clr_overrun -> rda, read_data, frame_err, parity_err, overrun, fifo_count
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          baud_tick,
  input  logic                          read_en,
  input  logic                          clr_overrun,
  output logic                          rda,
  output logic [DATA_BITS-1:0]          read_data,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_PARITY_EN
  localparam int EW = DATA_BITS + 2;
`else
  localparam int EW = DATA_BITS + 1;
`endif
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 4 ||
      OVERSAMPLE % 2 != 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_fifo: illegal parameter combination");
  end
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, nxt;
  logic rx_meta, rx_s;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic fe;
  logic mid_start, mid_bit, push, pop, full, wr;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] entry, head;
`ifdef UART_RX_PARITY_EN
  logic pe;
  assign entry = {pe, fe | ~rx_s, shift};
  assign parity_err = rda & head[DATA_BITS+1];
`else
  assign entry = {fe | ~rx_s, shift};
  assign parity_err = 1'b0;
`endif
  assign mid_start = baud_tick && tick_cnt == TW'(OVERSAMPLE / 2 - 1);
  assign mid_bit   = baud_tick && tick_cnt == TW'(OVERSAMPLE - 1);
  always_comb begin
    nxt  = state;
    push = 1'b0;
    case (state)
      IDLE:  nxt = rx_s ? IDLE : START;
      START: nxt = !mid_start ? START : rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   nxt = (mid_bit && bit_cnt == BW'(DATA_BITS - 1)) ? PARITY : DATA;
      PARITY: nxt = mid_bit ? STOP : PARITY;
`else
      DATA:   nxt = (mid_bit && bit_cnt == BW'(DATA_BITS - 1)) ? STOP : DATA;
`endif
      STOP: begin
        push = mid_bit && bit_cnt == BW'(STOP_BITS - 1);
        nxt  = push ? IDLE : STOP;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      fe       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe       <= 1'b0;
`endif
    end else begin
      rx_meta  <= rxd;
      rx_s     <= rx_meta;
      state    <= nxt;
      tick_cnt <= (state == IDLE || state != nxt || mid_bit) ? '0 : tick_cnt + TW'(baud_tick);
      bit_cnt  <= state != nxt ? '0 : bit_cnt + BW'(mid_bit);
      if (state == DATA && mid_bit) shift <= {rx_s, shift[DATA_BITS-1:1]};
      fe       <= state == START ? 1'b0 : (state == STOP && mid_bit && !rx_s) ? 1'b1 : fe;
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && mid_bit) pe <= rx_s ^ (^shift) ^ (PARITY_ODD != 0);
`endif
    end
  assign head      = mem[rd_ptr];
  assign rda       = fifo_count != '0;
  assign read_data = rda ? head[DATA_BITS-1:0] : '0;
  assign frame_err = rda & head[DATA_BITS];
  assign full      = fifo_count == CW'(FIFO_DEPTH);
  assign pop       = read_en && rda;
  assign wr        = push && (!full || pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(wr);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(wr) - CW'(pop);
      overrun    <= (push && full && !pop) || (overrun && !clr_overrun);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= entry;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo using a vector table, corner sequences and random frames against a queue model
module tb_uart_rx_fifo;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int OS   = 16;
  localparam int FD   = 4;
  localparam int PODD = 0;
  localparam int TD   = 4;
  localparam int BIT  = OS * TD;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int MID = (1 + DB + PB) * BIT + BIT / 2;
  typedef struct { logic [DB-1:0] d; logic stop_ok; logic exp_fe; } vec_t;
  typedef struct { logic [DB-1:0] d; logic fe; logic pe; } ent_t;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, baud_tick = 1'b0, read_en = 1'b0, clr_overrun = 1'b0;
  logic rda, frame_err, parity_err, overrun;
  logic [DB-1:0] read_data;
  logic [$clog2(FD):0] fifo_count;
  int n_cmp = 0, n_fail = 0, div = 0, lat = 0, n = 0;
  uart_rx_fifo #(.DATA_BITS(DB), .STOP_BITS(SB), .OVERSAMPLE(OS), .FIFO_DEPTH(FD), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .baud_tick(baud_tick), .read_en(read_en), .clr_overrun(clr_overrun),
    .rda(rda), .read_data(read_data), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    div = (div + 1) % TD;
    baud_tick = (div == 0);
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic bit_wait(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask
  task automatic align();
    while (div != 0) begin
      @(negedge clk);
      #1;
    end
  endtask
  function automatic logic par_bit(input logic [DB-1:0] d);
    return logic'(($countones(d) + PODD) % 2);
  endfunction
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok, input logic par);
    align();
    rxd = 1'b0;
    bit_wait(BIT);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      bit_wait(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    bit_wait(BIT);
`endif
    rxd = stop_ok;
    bit_wait(stop_ok ? BIT : BIT * 3 / 4);
    rxd = 1'b1;
    if (!stop_ok) bit_wait(BIT / 4);
  endtask
  task automatic pop1();
    read_en = 1'b1;
    @(negedge clk);
    #1;
    read_en = 1'b0;
  endtask
  task automatic chk_head(input string name, input logic [DB-1:0] d, input logic fe, input logic pe);
    chk({name, "_rda"}, rda, 1);
    chk({name, "_data"}, read_data, d);
    chk({name, "_frame_err"}, frame_err, fe);
    chk({name, "_parity_err"}, parity_err, pe);
  endtask
  vec_t tbl [6];
  ent_t q [$];
  logic m_ovr;
  logic [DB-1:0] d;
  logic sok, pok, pe_exp;
  initial begin
    tbl = '{'{8'hA5, 1'b1, 1'b0}, '{8'h3C, 1'b0, 1'b1}, '{8'h3D, 1'b1, 1'b0},
            '{8'h00, 1'b1, 1'b0}, '{8'hFF, 1'b1, 1'b0}, '{8'h80, 1'b0, 1'b1}};
    bit_wait(3);
    chk("reset_rda", rda, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_data", read_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_parity_err", parity_err, 0);
    rst = 1'b0;
    bit_wait(4);
    for (int i = 0; i < 6; i++) begin
      align();
      fork
        send_frame(tbl[i].d, tbl[i].stop_ok, par_bit(tbl[i].d));
        begin
          n = 0;
          while (!rda && n < 12 * BIT) begin
            @(negedge clk);
            n++;
          end
        end
      join
      if (i == 0) begin
        lat = n;
        chk("latency_window", int'(lat >= MID && lat <= MID + TD + 3), 1);
      end
      chk_head("tbl", tbl[i].d, tbl[i].exp_fe, 1'b0);
      chk("tbl_count", fifo_count, 1);
      pop1();
      chk("tbl_pop_rda", rda, 0);
      chk("tbl_pop_count", fifo_count, 0);
    end
    align();
    rxd = 1'b0;
    bit_wait(BIT / 2 - TD);
    rxd = 1'b1;
    bit_wait(2 * BIT);
    chk("glitch_rda", rda, 0);
    chk("glitch_count", fifo_count, 0);
    send_frame(8'h6B, 1'b1, par_bit(8'h6B));
    chk_head("after_glitch", 8'h6B, 1'b0, 1'b0);
    pop1();
    for (int i = 1; i <= 5; i++) send_frame(DB'(i), 1'b1, par_bit(DB'(i)));
    chk("ovr_count", fifo_count, 4);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_read", read_data, i);
      pop1();
    end
    chk("ovr_drained", rda, 0);
    chk("ovr_sticky", overrun, 1);
    clr_overrun = 1'b1;
    bit_wait(1);
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 0);
    for (int i = 1; i <= 4; i++) send_frame(DB'(i), 1'b1, par_bit(DB'(i)));
    align();
    fork
      send_frame(8'h05, 1'b1, par_bit(8'h05));
      begin
        repeat (lat - 1) @(negedge clk);
        #1;
        read_en = 1'b1;
        @(negedge clk);
        #1;
        read_en = 1'b0;
      end
    join
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_overrun", overrun, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_read", read_data, i);
      pop1();
    end
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    chk_head("par_bad", 8'h07, 1'b0, 1'b1);
    pop1();
    send_frame(8'h07, 1'b1, 1'b1);
    chk_head("par_good", 8'h07, 1'b0, 1'b0);
    pop1();
`endif
    send_frame(8'h11, 1'b1, par_bit(8'h11));
    send_frame(8'h22, 1'b1, par_bit(8'h22));
    chk("prerst_count", fifo_count, 2);
    align();
    rxd = 1'b0;
    bit_wait(3 * BIT + BIT / 2);
    rst = 1'b1;
    #1;
    chk("rst_async_rda", rda, 0);
    chk("rst_async_count", fifo_count, 0);
    rxd = 1'b1;
    bit_wait(2);
    rst = 1'b0;
    bit_wait(12 * BIT);
    chk("rst_no_spurious", fifo_count, 0);
    send_frame(8'h5A, 1'b1, par_bit(8'h5A));
    chk_head("after_rst", 8'h5A, 1'b0, 1'b0);
    chk("after_rst_count", fifo_count, 1);
    pop1();
    m_ovr = 1'b0;
    for (int k = 0; k < 30; k++) begin
      d = DB'($urandom_range(0, (1 << DB) - 1));
      sok = $urandom_range(0, 4) != 0;
      pok = $urandom_range(0, 3) != 0;
`ifdef UART_RX_PARITY_EN
      pe_exp = !pok;
`else
      pe_exp = 1'b0;
`endif
      send_frame(d, sok, par_bit(d) ^ !pok);
      if (q.size() == FD) m_ovr = 1'b1;
      else q.push_back('{d, !sok, pe_exp});
      chk("rnd_count", fifo_count, q.size());
      chk("rnd_overrun", overrun, m_ovr);
      if (q.size() != 0) chk_head("rnd", q[0].d, q[0].fe, q[0].pe);
      else chk("rnd_rda", rda, 0);
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        pop1();
        if (q.size() != 0) void'(q.pop_front());
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_overrun = 1'b1;
        bit_wait(1);
        clr_overrun = 1'b0;
        m_ovr = 1'b0;
      end
      chk("rnd_after_pop_count", fifo_count, q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
